// File: rtl/rx_stream_fifo_mem.sv
// rx_stream_fifo_mem: simple-dual-port DEPTH x 8 byte array.
// Synchronous write and asynchronous (combinational) read. It is kept as a
// separate block so it can be replaced by a vendor distributed-RAM primitive.
module rx_stream_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // Write port: stores one byte per cycle; contents are data, so no reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port is combinational so the head byte is visible the cycle after it is written.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_stream_fifo.sv
// rx_stream_fifo: byte FIFO between the UART receiver and the stream bridge.
// Converts the strobe-only receiver output into a valid/ready stream, and
// flags (sticky) any byte dropped because the FIFO was full.
// Optional feature: define RX_STREAM_FIFO_OVF_CNT_EN to add the ovf_count
// port and its 8-bit saturating dropped-byte counter.
module rx_stream_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    in_data,
   input  logic          in_stb,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   level,
   output logic          overflow,
   input  logic          ovf_clr
`ifdef RX_STREAM_FIFO_OVF_CNT_EN
   ,
   output logic [7:0]    ovf_count
`endif
);

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [AW:0] wp_q, wp_d;
   logic [AW:0] rp_q, rp_d;
   logic        ovf_q, ovf_d;

   logic        full;
   logic        pop;
   logic        push;
   logic        drop;

   assign level     = wp_q - rp_q;
   assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign out_valid = (wp_q != rp_q);
   assign pop       = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a strobe on a full FIFO is still accepted.
   assign push      = in_stb && (!full || pop);
   assign drop      = in_stb && full && !pop;

   rx_stream_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wp_q[AW-1:0]),
      .wdata_i (in_data),
      .raddr_i (rp_q[AW-1:0]),
      .rdata_o (out_data)
   );

   // Next-state for pointers and the sticky overflow flag; a drop wins over a clear.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      ovf_d = ovf_q;
      if (push) begin
         wp_d = wp_q + 1'b1;
      end
      if (pop) begin
         rp_d = rp_q + 1'b1;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   // Pointer and flag registers; reset discards all stored bytes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;

`ifdef RX_STREAM_FIFO_OVF_CNT_EN
   logic [7:0] cnt_q, cnt_d;

   // Dropped-byte counter: saturates at 255; a drop during a clear restarts it at 1.
   always_comb begin
      cnt_d = cnt_q;
      if (drop) begin
         if (ovf_clr) begin
            cnt_d = 8'd1;
         end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (ovf_clr) begin
         cnt_d = 8'd0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ovf_count = cnt_q;
`endif

endmodule

// File: doc/rx_stream_fifo.md
# rx_stream_fifo

Byte FIFO that sits between the UART receiver and the stream-to-Wishbone bridge. It absorbs bursts of received bytes while the bridge is stalled on a Wishbone cycle or a TX response. It converts the receiver's strobe-only output, which has no backpressure, into a valid/ready stream and flags any byte lost to overflow. Ahead of this block, a byte arriving while the bridge is busy is silently dropped.

## Interface
- DEPTH, 16, number of byte entries; power of two, minimum 2
- AW, $clog2(DEPTH), derived pointer width; not to be overridden
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  received byte, qualified by in_stb
- in_stb  in  1  single-cycle strobe from uart_rx; no backpressure
- out_data  out  8  head byte, valid when out_valid=1
- out_valid  out  1  head byte available
- out_ready  in  1  consumer accepts the head byte this cycle when out_valid=1
- level  out  AW+1  number of bytes currently stored, 0..DEPTH
- overflow  out  1  sticky flag: at least one byte dropped since the last clear
- ovf_clr  in  1  single-cycle clear of overflow (and ovf_count)
- ovf_count  out  8  saturating count of dropped bytes (present only with RX_STREAM_FIFO_OVF_CNT_EN)

## Operation
- Storage is a DEPTH x 8 array with write pointer wp and read pointer rp, each AW+1 bits wide.
- Empty when wp==rp. Full when the pointers differ only in the MSB. level = wp - rp, taken modulo 2^(AW+1).
- Push: in_stb=1 and (not full, or a pop happens in the same cycle) writes mem[wp[AW-1:0]] and increments wp.
- Pop: out_valid=1 and out_ready=1 increments rp.
- Pointer wrap is natural binary wrap at 2^(AW+1). No special case.
- Simultaneous push and pop:
  - Both take effect and level is unchanged. This includes the full case: the pop frees the slot and the push is accepted, so no overflow.
  - In the empty case the byte takes the normal path: stored this cycle, visible next cycle.
- Overflow: in_stb=1 while full with no pop → byte discarded, pointers unchanged, overflow set to 1.
- ovf_clr=1 clears overflow. If a drop occurs in the same cycle, set wins and overflow stays 1.
- out_valid = (level != 0). out_data = mem[rp[AW-1:0]], read combinationally from the array.
- out_data is stable while out_valid=1 and out_ready=0.
- No byte is ever reordered or duplicated.

## Timing
- Reset values: wp=rp=0, out_valid=0, level=0, overflow=0, ovf_count=0. out_data is undefined.
- Reset is asynchronous: outputs take their reset values immediately on rst assertion, including mid-transfer.
- All stored bytes are discarded on reset. Operation resumes on the first clk edge after deassertion.
- Latency: in_stb at edge N on an empty FIFO gives out_valid=1 and the byte on out_data after edge N. It can be popped at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- level and overflow update on the same edge as the push, pop, or drop that changes them.

## Configuration
- RX_STREAM_FIFO_OVF_CNT_EN defined:
  - ovf_count port and an 8-bit counter are present.
  - The counter increments by 1 on each dropped byte and saturates at 255.
  - ovf_clr zeroes it. A drop in the same cycle as ovf_clr leaves it at 1.
- RX_STREAM_FIFO_OVF_CNT_EN undefined:
  - The port and counter are absent.
  - The overflow flag behaves identically.

## Structure
- No shared package. DEPTH/AW are module parameters and the block has no typedefs.
- One natural sub-module: rx_stream_fifo_mem, a simple-dual-port DEPTH x 8 array with synchronous write and asynchronous read. It is kept separate so it can be swapped for a vendor primitive.
- The top level holds the pointers, flags and the optional counter.

## Test plan
- Single byte: reset, in_stb with 0xA5 → out_valid=1 next cycle, out_data=0xA5, level=1; pop → level=0, out_valid=0.
- Burst fill: DEPTH=16, out_ready=0, push 0x00..0x0F → level=16, overflow=0. Drain with out_ready=1 → bytes 0x00..0x0F in order, one per cycle.
- Overflow: full FIFO, 3 more strobes with out_ready=0 → overflow=1, ovf_count=3, contents unchanged.
  - ovf_clr → overflow=0, ovf_count=0.
- Full + simultaneous push/pop: full, in_stb with 0x55 and out_ready=1 in the same cycle → level stays 16, overflow=0, 0x55 emerges last.
- Wrap: 40 bytes streamed with random out_ready stalls → output sequence identical to input, level never exceeds 16.
- Reset mid-operation: level=7, assert rst asynchronously → out_valid=0 and level=0 before the next edge. After release, a new byte 0x3C is the first output.
